// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: central stall/flush sequencer for load-use, taken-branch and multi-cycle hazards (HAZARD_PERF_CNT_EN adds stall/flush cycle counters)
module pipeline_hazard_sequencer #(
   parameter int WIDTH             = 32,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int MC_TIMEOUT        = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             branch_taken,
   input  logic             mc_start,
   input  logic             mc_done,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             mc_timeout,
   output logic [1:0]       state,
   output logic [WIDTH-1:0] stall_cycles,
   output logic [WIDTH-1:0] flush_cycles
);
   typedef enum logic [1:0] {RUN = 2'b00, LSTALL = 2'b01, FLUSH = 2'b10, MCWAIT = 2'b11} state_t;
   localparam logic [7:0] LS_INIT = 8'(LOAD_STALL_CYCLES - 1);
   localparam logic [7:0] FL_INIT = 8'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TO_LAST = 8'(MC_TIMEOUT - 1);
   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic luh, stall, mc, fl;
   assign luh = ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
   // state and counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // next state: a taken branch overrides whatever the current state is doing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (branch_taken) begin
         state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
         cnt_d   = FL_INIT;
      end else begin
         case (state_q)
            RUN: begin
               if (luh) begin
                  state_d = LOAD_STALL_CYCLES > 1 ? LSTALL : RUN;
                  cnt_d   = LS_INIT;
               end else if (mc_start && !mc_done) begin
                  state_d = MCWAIT;
                  cnt_d   = 8'd0;
               end
            end
            LSTALL, FLUSH: begin
               cnt_d   = cnt_q - 8'd1;
               state_d = cnt_q <= 8'd1 ? RUN : state_q;
            end
            default: begin
               cnt_d   = cnt_q + 8'd1;
               state_d = (mc_done || cnt_q >= TO_LAST) ? RUN : MCWAIT;
            end
         endcase
      end
   end
   // outputs: reset forces the safe bubble/flush pattern combinationally
   always_comb begin
      stall       = state_q == LSTALL || (state_q == RUN && luh);
      mc          = state_q == MCWAIT;
      fl          = branch_taken || state_q == FLUSH;
      pc_en       = rst_n && (fl || !(stall || mc));
      ifid_en     = rst_n && (fl || !(stall || mc));
      ifid_flush  = !rst_n || fl;
      idex_bubble = !rst_n || fl || stall || mc;
      mc_timeout  = rst_n && !branch_taken && mc && !mc_done && cnt_q == TO_LAST;
      state       = state_q;
   end
`ifdef HAZARD_PERF_CNT_EN
   logic [WIDTH-1:0] stall_q, flush_q;
   // saturating counts of stalled and flushing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= (!pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
         flush_q <= (ifid_flush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
      end
   end
   assign stall_cycles = stall_q;
   assign flush_cycles = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer: directed scoreboard bench for the hazard sequencer
module tb_pipeline_hazard_sequencer;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic id_uses_rs2 = 0, ex_memread = 0, branch_taken = 0, mc_start = 0, mc_done = 0;
   logic pc_en, ifid_en, ifid_flush, idex_bubble, mc_timeout;
   logic [1:0] state;
   logic [31:0] stall_cycles, flush_cycles;
   int tests = 0, fails = 0;
   typedef struct {string nm; logic [6:0] e; bit z;} item_t;
   item_t q[$];

   localparam logic [6:0] RST = 7'b0011000, RUNO = 7'b1100000, LUHO = 7'b0001000, LSTO = 7'b0001001;
   localparam logic [6:0] BRO = 7'b1111000, FLO = 7'b1111010, MCO = 7'b0001011, TOO = 7'b0001111;

   pipeline_hazard_sequencer #(.WIDTH(32), .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(3), .MC_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken), .mc_start(mc_start),
      .mc_done(mc_done), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .mc_timeout(mc_timeout), .state(state),
      .stall_cycles(stall_cycles), .flush_cycles(flush_cycles));

   always #5 clk = ~clk;

   // drive one cycle of inputs just after the rising edge and queue the expected outputs
   task automatic cyc(input string nm, input logic [6:0] e, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u2, input logic bt,
                      input logic ms, input logic md, input logic r = 1'b1, input bit z = 1'b0);
      @(posedge clk);
      #1;
      rst_n = r; ex_memread = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
      branch_taken = bt; mc_start = ms; mc_done = md;
      q.push_back('{nm, e, z});
   endtask

   task automatic idle(input string nm, input logic [6:0] e, input bit z = 1'b0);
      cyc(nm, e, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, z);
   endtask

   // monitor: compare DUT outputs against the queued expectation on the falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         item_t it;
         logic [6:0] a;
         it = q.pop_front();
         a = {pc_en, ifid_en, ifid_flush, idex_bubble, mc_timeout, state};
         tests++;
         if (a !== it.e || ifid_en !== pc_en) begin
            fails++;
            $display("FAIL %s: got pc/ifid/flush/bubble/to/state=%b required %b", it.nm, a, it.e);
         end
`ifdef HAZARD_PERF_CNT_EN
         if (it.z) begin
`else
         begin
`endif
            tests++;
            if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
               fails++;
               $display("FAIL %s_cnt: got stall=%0d flush=%0d required 0 0", it.nm, stall_cycles, flush_cycles);
            end
         end
      end
   end

   initial begin
      cyc("reset0", RST, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cyc("reset1", RST, 1, 5, 5, 5, 1, 1, 1, 0, 1'b0, 1'b1);
      idle("run_idle", RUNO, 1'b1);
      // load-use through rs2, two bubbles
      cyc("luh_rs2", LUHO, 1, 5, 3, 5, 1, 0, 0, 0);
      cyc("lstall", LSTO, 1, 5, 3, 5, 1, 0, 0, 0);
      idle("luh_done", RUNO);
      // load-use through rs1 only
      cyc("luh_rs1", LUHO, 1, 7, 7, 2, 0, 0, 0, 0);
      cyc("lstall_rs1", LSTO, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("rs1_done", RUNO);
      // rs2 match ignored when rs2 is not read
      cyc("no_u2", RUNO, 1, 5, 3, 5, 0, 0, 0, 0);
      // x0 never stalls
      cyc("rd0_a", RUNO, 1, 0, 0, 0, 1, 0, 0, 0);
      cyc("rd0_b", RUNO, 1, 0, 0, 0, 1, 0, 0, 0);
      // branch flush of three cycles
      cyc("br", BRO, 0, 0, 0, 0, 0, 1, 0, 0);
      idle("flush1", FLO);
      idle("flush2", FLO);
      idle("br_done", RUNO);
      // multi-cycle op, done on the fifth wait cycle
      cyc("mc_issue", RUNO, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 4; i++) idle($sformatf("mcwait%0d", i), MCO);
      cyc("mc_done", MCO, 0, 0, 0, 0, 0, 0, 0, 1);
      idle("mc_back", RUNO);
      // no done: timeout pulse on the eighth wait cycle
      cyc("to_issue", RUNO, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 7; i++) idle($sformatf("towait%0d", i), MCO);
      idle("timeout", TOO);
      idle("to_back", RUNO);
      // done arriving with the timeout wins, no pulse
      cyc("tod_issue", RUNO, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 7; i++) idle($sformatf("todwait%0d", i), MCO);
      cyc("to_and_done", MCO, 0, 0, 0, 0, 0, 0, 0, 1);
      idle("tod_back", RUNO);
      // start with done in the same cycle stays in RUN
      cyc("mc_fast", RUNO, 0, 0, 0, 0, 0, 0, 1, 1);
      idle("mc_fast_run", RUNO);
      // branch beats a simultaneous load-use
      cyc("br_luh", BRO, 1, 5, 5, 0, 0, 1, 0, 0);
      idle("brl_f1", FLO);
      idle("brl_f2", FLO);
      idle("brl_done", RUNO);
      // branch aborts an LSTALL
      cyc("luh2", LUHO, 1, 9, 9, 0, 0, 0, 0, 0);
      cyc("br_in_lstall", 7'b1111001, 0, 0, 0, 0, 0, 1, 0, 0);
      idle("bls_f1", FLO);
      idle("bls_f2", FLO);
      idle("bls_done", RUNO);
      // branch aborts MCWAIT at its timeout cycle, suppressing the pulse
      cyc("brm_issue", RUNO, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 7; i++) idle($sformatf("brmwait%0d", i), MCO);
      cyc("br_at_timeout", 7'b1111011, 0, 0, 0, 0, 0, 1, 0, 0);
      idle("brm_f1", FLO);
      idle("brm_f2", FLO);
      idle("brm_done", RUNO);
      // reset asserted mid-MCWAIT
      cyc("rm_issue", RUNO, 0, 0, 0, 0, 0, 0, 1, 0);
      idle("rm_wait1", MCO);
      idle("rm_wait2", MCO);
      cyc("rst_mid", RST, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cyc("rst_hold", RST, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      idle("after_rst", RUNO, 1'b1);
      idle("after_rst2", RUNO);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
